// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared width, bus-source and ALU-op encodings for data_path
package datapath_pkg;

  localparam int DATA_W = 32;

  // One-hot bus source; bit order matches the {MDRout..R3out} strobe vector
  typedef enum logic [6:0] {
    SRC_NONE = 7'b0000000,
    SRC_R3   = 7'b0000001,
    SRC_R2   = 7'b0000010,
    SRC_R1   = 7'b0000100,
    SRC_ZLO  = 7'b0001000,
    SRC_ZHI  = 7'b0010000,
    SRC_PC   = 7'b0100000,
    SRC_MDR  = 7'b1000000
  } bus_src_e;

  typedef enum logic [3:0] {
    OP_PASS, OP_INC, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
    OP_SHL, OP_SHR, OP_ROL, OP_ROR
  } alu_op_e;

  // outs = {MDRout, PCout, Zhighout, Zlowout, R1out, R2out, R3out}
  function automatic bus_src_e bus_src_sel(input logic [6:0] outs);
    if (outs[6])      return SRC_MDR;
    else if (outs[5]) return SRC_PC;
    else if (outs[4]) return SRC_ZHI;
    else if (outs[3]) return SRC_ZLO;
    else if (outs[2]) return SRC_R1;
    else if (outs[1]) return SRC_R2;
    else if (outs[0]) return SRC_R3;
    else              return SRC_NONE;
  endfunction

  // ops = {IncPC, ADD, SUB, AND, OR, NOT, SHL, SHR, ROL, ROR}
  function automatic alu_op_e alu_op_sel(input logic [9:0] ops);
    if (ops[9])      return OP_INC;
    else if (ops[8]) return OP_ADD;
    else if (ops[7]) return OP_SUB;
    else if (ops[6]) return OP_AND;
    else if (ops[5]) return OP_OR;
    else if (ops[4]) return OP_NOT;
    else if (ops[3]) return OP_SHL;
    else if (ops[2]) return OP_SHR;
    else if (ops[1]) return OP_ROL;
    else if (ops[0]) return OP_ROR;
    else             return OP_PASS;
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// rtl/datapath_alu.sv - combinational ALU, A=Y, B=bus; shift ops under DATAPATH_SHIFT_EN
module datapath_alu
  import datapath_pkg::*;
(
  input  alu_op_e             op_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [DATA_W-1:0]   result_o
);

`ifdef DATAPATH_SHIFT_EN
  logic [4:0] sh;
  assign sh = b_i[4:0];
`endif

  // Select the result for the decoded op; unknown/idle op passes B through
  always_comb begin
    result_o = b_i;
    case (op_i)
      OP_INC:  result_o = b_i + 32'd1;
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_NOT:  result_o = ~b_i;
`ifdef DATAPATH_SHIFT_EN
      OP_SHL:  result_o = a_i << sh;
      OP_SHR:  result_o = a_i >> sh;
      // a shift by 32 yields 0, so a zero rotate amount returns A unchanged
      OP_ROL:  result_o = (a_i << sh) | (a_i >> (6'd32 - {1'b0, sh}));
      OP_ROR:  result_o = (a_i >> sh) | (a_i << (6'd32 - {1'b0, sh}));
`endif
      default: result_o = b_i;
    endcase
  end

endmodule

// File: rtl/data_path.sv
// rtl/data_path.sv - single-bus CPU datapath top; optional DATAPATH_SHIFT_EN adds SHL/SHR/ROL/ROR
module data_path
  import datapath_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  input  logic               R1in,
  input  logic               R2in,
  input  logic               R3in,
  input  logic               R1out,
  input  logic               R2out,
  input  logic               R3out,
  input  logic               PCin,
  input  logic               PCout,
  input  logic               MARin,
  input  logic               MDRin,
  input  logic               MD_read,
  input  logic               MDRout,
  input  logic               IRin,
  input  logic               Yin,
  input  logic               Zin,
  input  logic               Zlowout,
  input  logic               Zhighout,
  input  logic               IncPC,
  input  logic               ADD,
  input  logic               SUB,
  input  logic               AND,
  input  logic               OR,
  input  logic               NOT,
`ifdef DATAPATH_SHIFT_EN
  input  logic               SHL,
  input  logic               SHR,
  input  logic               ROL,
  input  logic               ROR,
`endif
  input  logic [DATA_W-1:0]  Mdatain,
  output logic [DATA_W-1:0]  BusMuxOut,
  output logic [DATA_W-1:0]  IR_q,
  output logic [DATA_W-1:0]  MAR_q,
  output logic [DATA_W-1:0]  PC_q
);

  logic [DATA_W-1:0]   MDR_q, Y_q, R1_q, R2_q, R3_q;
  logic [DATA_W-1:0]   MDR_d, Y_d, R1_d, R2_d, R3_d, IR_d, MAR_d, PC_d;
  logic [2*DATA_W-1:0] Z_q, Z_d;
  bus_src_e            bus_src;
  alu_op_e             alu_op;
  logic [DATA_W-1:0]   alu_res;

  assign bus_src = bus_src_sel({MDRout, PCout, Zhighout, Zlowout, R1out, R2out, R3out});

`ifdef DATAPATH_SHIFT_EN
  assign alu_op = alu_op_sel({IncPC, ADD, SUB, AND, OR, NOT, SHL, SHR, ROL, ROR});
`else
  assign alu_op = alu_op_sel({IncPC, ADD, SUB, AND, OR, NOT, 4'b0000});
`endif

  // Bus mux: drive the highest-priority source, 0 when nothing drives
  always_comb begin
    BusMuxOut = '0;
    case (bus_src)
      SRC_MDR: BusMuxOut = MDR_q;
      SRC_PC:  BusMuxOut = PC_q;
      SRC_ZHI: BusMuxOut = Z_q[2*DATA_W-1:DATA_W];
      SRC_ZLO: BusMuxOut = Z_q[DATA_W-1:0];
      SRC_R1:  BusMuxOut = R1_q;
      SRC_R2:  BusMuxOut = R2_q;
      SRC_R3:  BusMuxOut = R3_q;
      default: BusMuxOut = '0;
    endcase
  end

  datapath_alu u_alu (
    .op_i     (alu_op),
    .a_i      (Y_q),
    .b_i      (BusMuxOut),
    .result_o (alu_res)
  );

  // Next-state: each register holds unless its load strobe is high
  always_comb begin
    R1_d  = R1in  ? BusMuxOut : R1_q;
    R2_d  = R2in  ? BusMuxOut : R2_q;
    R3_d  = R3in  ? BusMuxOut : R3_q;
    PC_d  = PCin  ? BusMuxOut : PC_q;
    MAR_d = MARin ? BusMuxOut : MAR_q;
    IR_d  = IRin  ? BusMuxOut : IR_q;
    Y_d   = Yin   ? BusMuxOut : Y_q;
    MDR_d = MDR_q;
    if (MDRin) MDR_d = MD_read ? Mdatain : BusMuxOut;
    Z_d   = Zin   ? {{DATA_W{1'b0}}, alu_res} : Z_q;
  end

  // State registers; clear low forces everything to zero regardless of strobes
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      R1_q  <= '0;
      R2_q  <= '0;
      R3_q  <= '0;
      PC_q  <= '0;
      MAR_q <= '0;
      IR_q  <= '0;
      Y_q   <= '0;
      MDR_q <= '0;
      Z_q   <= '0;
    end else begin
      R1_q  <= R1_d;
      R2_q  <= R2_d;
      R3_q  <= R3_d;
      PC_q  <= PC_d;
      MAR_q <= MAR_d;
      IR_q  <= IR_d;
      Y_q   <= Y_d;
      MDR_q <= MDR_d;
      Z_q   <= Z_d;
    end
  end

endmodule

// File: tb/tb_data_path.sv
// tb/tb_data_path.sv - directed self-checking bench for data_path
module tb_data_path;

  logic        clock = 1'b0;
  logic        clear;
  logic        R1in, R2in, R3in, R1out, R2out, R3out;
  logic        PCin, PCout, MARin, MDRin, MD_read, MDRout, IRin, Yin, Zin;
  logic        Zlowout, Zhighout, IncPC, ADD, SUB, AND, OR, NOT;
`ifdef DATAPATH_SHIFT_EN
  logic        SHL, SHR, ROL, ROR;
`endif
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut, IR_q, MAR_q, PC_q;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  data_path dut (
    .clock(clock), .clear(clear),
    .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .R1out(R1out), .R2out(R2out), .R3out(R3out),
    .PCin(PCin), .PCout(PCout), .MARin(MARin), .MDRin(MDRin),
    .MD_read(MD_read), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout),
    .IncPC(IncPC), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .NOT(NOT),
`ifdef DATAPATH_SHIFT_EN
    .SHL(SHL), .SHR(SHR), .ROL(ROL), .ROR(ROR),
`endif
    .Mdatain(Mdatain), .BusMuxOut(BusMuxOut),
    .IR_q(IR_q), .MAR_q(MAR_q), .PC_q(PC_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic clr_all();
    {R1in, R2in, R3in, R1out, R2out, R3out} = '0;
    {PCin, PCout, MARin, MDRin, MD_read, MDRout, IRin, Yin, Zin} = '0;
    {Zlowout, Zhighout, IncPC, ADD, SUB, AND, OR, NOT} = '0;
`ifdef DATAPATH_SHIFT_EN
    {SHL, SHR, ROL, ROR} = '0;
`endif
  endtask

  // k: 0 MDR, 1 PC, 2 Zhigh, 3 Zlow, 4 R1, 5 R2, 6 R3
  task automatic set_out(input int k);
    clr_all();
    case (k)
      0: MDRout = 1'b1;
      1: PCout = 1'b1;
      2: Zhighout = 1'b1;
      3: Zlowout = 1'b1;
      4: R1out = 1'b1;
      5: R2out = 1'b1;
      default: R3out = 1'b1;
    endcase
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clr_all();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    clr_all();
    Mdatain = v; MD_read = 1'b1; MDRin = 1'b1;
    tick();
  endtask

  initial begin
    clr_all();
    Mdatain = '0;
    clear = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    // 1. reset state
    check("rst_pc", PC_q, 32'h0);
    check("rst_ir", IR_q, 32'h0);
    check("rst_mar", MAR_q, 32'h0);
    check("rst_bus_idle", BusMuxOut, 32'h0);
    clear = 1'b1;
    for (int k = 0; k < 7; k++) begin
      set_out(k); #1;
      check($sformatf("rst_src%0d", k), BusMuxOut, 32'h0);
    end
    clr_all();
    {R1in, R2in, R3in, PCin, MARin, MDRin, IRin, Yin, Zin} = '1;
    tick();
    check("idle_pc", PC_q, 32'h0);
    check("idle_ir", IR_q, 32'h0);
    check("idle_mar", MAR_q, 32'h0);
    set_out(2); #1; check("idle_zhi", BusMuxOut, 32'h0);

    // 2. memory loads into R2/R3/R1
    load_mdr(32'h12); MDRout = 1'b1; R2in = 1'b1; #1;
    check("bus_mdr12", BusMuxOut, 32'h12);
    tick();
    load_mdr(32'h14); MDRout = 1'b1; R3in = 1'b1; tick();
    load_mdr(32'h18); MDRout = 1'b1; R1in = 1'b1; tick();
    set_out(5); #1; check("r2", BusMuxOut, 32'h12);
    set_out(6); #1; check("r3", BusMuxOut, 32'h14);
    set_out(4); #1; check("r1", BusMuxOut, 32'h18);

    // 3. AND R2,R3 -> R1
    clr_all(); R2out = 1'b1; Yin = 1'b1; tick();
    R3out = 1'b1; AND = 1'b1; Zin = 1'b1; tick();
    Zlowout = 1'b1; R1in = 1'b1; #1;
    check("and_zlo", BusMuxOut, 32'h10);
    tick();
    set_out(2); #1; check("and_zhi", BusMuxOut, 32'h0);
    set_out(4); #1; check("and_r1", BusMuxOut, 32'h10);
    // self-reload leaves R1 unchanged
    clr_all(); R1out = 1'b1; R1in = 1'b1; tick();
    set_out(4); #1; check("r1_selfload", BusMuxOut, 32'h10);

    // 4. fetch: MAR<-PC, PC<-PC+1, IR<-mem
    clr_all(); PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; tick();
    check("mar_fetch", MAR_q, 32'h0);
    Zlowout = 1'b1; PCin = 1'b1; #1;
    check("pc_same_cycle_old", PC_q, 32'h0);
    tick();
    check("pc_inc", PC_q, 32'h1);
    load_mdr(32'h28918000); MDRout = 1'b1; IRin = 1'b1; tick();
    check("ir_load", IR_q, 32'h28918000);

    // 5. bus priority and ALU wrap
    clr_all(); MDRout = 1'b1; R2out = 1'b1; #1;
    check("prio_mdr_r2", BusMuxOut, 32'h28918000);
    clr_all(); PCout = 1'b1; Zlowout = 1'b1; R1out = 1'b1; #1;
    check("prio_pc_z_r1", BusMuxOut, 32'h1);
    clr_all(); #1;
    check("bus_none", BusMuxOut, 32'h0);
    load_mdr(32'hFFFFFFFF); MDRout = 1'b1; Yin = 1'b1; tick();
    PCout = 1'b1; ADD = 1'b1; Zin = 1'b1; tick();
    set_out(3); #1; check("add_wrap_lo", BusMuxOut, 32'h0);
    set_out(2); #1; check("add_wrap_hi", BusMuxOut, 32'h0);
    clr_all(); PCout = 1'b1; ADD = 1'b1; SUB = 1'b1; NOT = 1'b1; Zin = 1'b1; tick();
    set_out(3); #1; check("op_prio_add", BusMuxOut, 32'h0);
    clr_all(); PCout = 1'b1; OR = 1'b1; NOT = 1'b1; Zin = 1'b1; tick();
    set_out(3); #1; check("or_over_not", BusMuxOut, 32'hFFFFFFFF);
    clr_all(); R1out = 1'b1; NOT = 1'b1; Zin = 1'b1; tick();
    set_out(3); #1; check("not_r1", BusMuxOut, 32'hFFFFFFEF);
    clr_all(); R3out = 1'b1; Zin = 1'b1; tick();
    set_out(3); #1; check("pass_r3", BusMuxOut, 32'h14);
    clr_all(); PCout = 1'b1; SUB = 1'b1; Zin = 1'b1; tick();
    set_out(3); #1; check("sub", BusMuxOut, 32'hFFFFFFFE);

`ifdef DATAPATH_SHIFT_EN
    load_mdr(32'h80000001); MDRout = 1'b1; Yin = 1'b1; tick();
    load_mdr(32'h1); MDRout = 1'b1; ROL = 1'b1; Zin = 1'b1; tick();
    set_out(3); #1; check("rol", BusMuxOut, 32'h3);
    clr_all(); MDRout = 1'b1; NOT = 1'b1; Zin = 1'b1; tick();
    load_mdr(32'hFFFFFFFE);
`endif

    // 6. clear asserted mid-cycle during a Zin operation
    clr_all(); Zlowout = 1'b1; NOT = 1'b1; Zin = 1'b1; #1;
    check("pre_clear_z", BusMuxOut, 32'hFFFFFFFE);
    clear = 1'b0; #1;
    check("clear_z_now", BusMuxOut, 32'h0);
    check("clear_pc_now", PC_q, 32'h0);
    check("clear_ir_now", IR_q, 32'h0);
    @(posedge clock); #1;
    Zlowout = 1'b1; #1;
    check("clear_no_load", BusMuxOut, 32'h0);
    clr_all();
    clear = 1'b1;
    tick();
    set_out(3); #1; check("after_clear_z", BusMuxOut, 32'h0);
    clr_all();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
